mdu_iter: RTL and testbench
===========================

// Module: mdu_iter
// PURPOSE
//  Iterative RV64M multiply/divide unit in the execute stage. It is the producer side of the
//  hazard unit's e_wait input. It consumes the stallE/flushE controls the hazard unit returns.
//  It holds e_wait high while an operation runs and presents a stable result until E advances.
//  One operation is in flight at a time; there is no internal queue.
// PARAMETERS
//  XLEN      64   datapath width (only 64 supported; W ops use the low 32 bits)
// PORTS
//  clk       in   1     clock; single clock domain
//  reset     in   1     asynchronous, active-high reset
//  valid     in   1     E-stage instruction is an M-extension op (multialuE)
//  op        in   4     mdu_op_t operation code
//  a         in   XLEN  rs1 operand, already forwarded
//  b         in   XLEN  rs2 operand, already forwarded
//  stall     in   1     stallE from the hazard unit
//  flush     in   1     flushE from the hazard unit (covers the mret flush)
//  e_wait    out  1     busy indication to the hazard unit
//  done      out  1     result valid for the instruction currently in E
//  result    out  XLEN  rd value, sign-extended for W ops
// BEHAVIOUR
//  - Reset: state=IDLE, cnt=0, all working regs=0, result=0, done=0, e_wait=0.
//    Reset may assert mid-operation: the operation is discarded and no partial result appears.
//  - States: IDLE, BUSY, DONE.
//  - IDLE, valid & ~flush:
//    * Capture operands and op.
//    * e_wait=1 combinationally in this same cycle, so E stalls immediately.
//    * Next state is BUSY, or DONE for the special cases listed below.
//  - BUSY:
//    * One radix-2 step per cycle: shift-add for MUL*, restoring subtract for DIV/REM.
//    * N = 64 steps for 64-bit ops, N = 32 steps for *W ops.
//    * Sign correction is applied on the last step; the next state is DONE.
//    * e_wait=1 for the whole state.
//  - DONE:
//    * e_wait=0, done=1, result held stable.
//    * Stay in DONE while stall=1 (for example d_wait holds E); never restart on the still-high valid.
//    * Go to IDLE when stall=0, which is the edge on which E advances to M.
//  - Latency, typical 64-bit op: valid seen in cycle 0; BUSY in cycles 1..64; DONE in cycle 65.
//    * *W ops reach DONE in cycle 33.
//    * Special cases reach DONE in cycle 1.
//  - flush=1 in any state: next state is IDLE, the operation is dropped, done=0 next cycle.
//    * In IDLE, flush has priority over valid, so no capture occurs.
//    * e_wait is not masked by flush in BUSY; the hazard unit gives flush precedence.
//  - Operand preparation:
//    * Signed ops (MULH, DIV, REM) take magnitudes of both operands.
//    * MULHSU treats a as signed and b as unsigned.
//    * MULHU, DIVU and REMU are fully unsigned.
//    * *W ops sign-extend bits [31:0] of each operand (DIVUW/REMUW zero-extend), then use 32 steps.
//  - Result selection:
//    * MUL/MULW take the low product half; MULH* take the high 64 bits of the 128-bit product.
//    * DIV* take the quotient and REM* the remainder; remainder sign = dividend sign.
//    * All *W results are sign-extended from bit 31.
//  - Special cases:
//    * Divide by zero: quotient = all ones, remainder = dividend.
//    * Signed overflow (most-negative / -1): quotient = dividend, remainder = 0.
//    * Both are evaluated at the XLEN or 32-bit width that matches the op.
//  - cnt is 7 bits; it never wraps because BUSY exits on cnt==N-1.
// STRUCTURE
//  - Package pipes gains: typedef enum logic[3:0] mdu_op_t
//    {MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU, MULW, DIVW, DIVUW, REMW, REMUW}.
//  - Package pipes also gains: typedef enum logic[1:0] mdu_state_t {IDLE, BUSY, DONE}.
//  - Sub-module mdu_div_step: one combinational restoring-divide step (rem, quo, divisor -> next).
//    The multiply step stays inline.
// TESTING
//  - DIV 100 by 7: e_wait=1 from cycle 0 through cycle 64; cycle 65: done=1, result=14.
//    REM on the same operands -> result=2.
//  - MULH 0x8000_0000_0000_0000 x -1 -> 0x0000_0000_0000_0000; MUL low half -> 0x8000_0000_0000_0000.
//    MULHU all-ones x all-ones -> 0xFFFF_FFFF_FFFF_FFFE.
//  - DIV 5 by 0: done in cycle 1, result=0xFFFF_FFFF_FFFF_FFFF.
//    DIV INT64_MIN by -1 -> result=INT64_MIN; REM INT64_MIN by -1 -> result=0.
//  - DIVW a=0x0000_0000_8000_0000, b=0xFFFF_FFFF_FFFF_FFFF: done in cycle 1, result=0xFFFF_FFFF_8000_0000.
//    MULW 0x7FFF_FFFF x 2 -> result=0xFFFF_FFFF_FFFF_FFFE, done in cycle 33.
//  - Hold in DONE: assert stall for 5 cycles after DONE with valid still high.
//    Required: done stays 1, result stable, e_wait=0, no restart; release stall -> IDLE.
//  - Abort: flush in BUSY cycle 10 -> IDLE next cycle, done never asserts.
//    Assert reset in BUSY cycle 20 -> all outputs 0; a new DIVU 9 by 2 afterwards -> result=4.

Source files
------------

// File: rtl/pipes.sv
// pipes: shared pipeline types for the execute-stage multiply/divide unit.
//   mdu_op_t    - M-extension operation code carried from decode into E
//   mdu_state_t - sequencing state of the iterative multiply/divide unit
//   sext32      - sign-extend a 32-bit word result to 64 bits
//   neg_if      - conditional two's-complement negate (magnitude <-> signed)
package pipes;

  typedef enum logic [3:0] {
    MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU,
    MULW, DIVW, DIVUW, REMW, REMUW
  } mdu_op_t;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} mdu_state_t;

  function automatic logic [63:0] sext32(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

  function automatic logic [63:0] neg_if(input logic [63:0] v, input logic n);
    return n ? (64'd0 - v) : v;
  endfunction

endpackage

// File: rtl/mdu_div_step.sv
// mdu_div_step: one radix-2 restoring-divide step.
//   rem_i     - partial remainder (always < divisor_i)
//   quo_i     - dividend bits still to be consumed (MSB first) / quotient bits produced so far
//   divisor_i - divisor magnitude
//   rem_o     - next partial remainder
//   quo_o     - quo_i shifted left with the new quotient bit in bit 0
module mdu_div_step
  import pipes::*;
(
  input  logic [63:0] rem_i,
  input  logic [63:0] quo_i,
  input  logic [63:0] divisor_i,
  output logic [63:0] rem_o,
  output logic [63:0] quo_o
);

  logic [64:0] shifted_s;
  logic        ge_s;
  logic [63:0] diff_s;

  // Shift in the next dividend bit and subtract when the divisor fits.
  // The shifted remainder can reach 65 bits, but the difference is always
  // below the divisor, so a 64-bit subtraction is exact.
  always_comb begin
    shifted_s = {rem_i, quo_i[63]};
    ge_s      = (shifted_s >= {1'b0, divisor_i});
    diff_s    = shifted_s[63:0] - divisor_i;
    if (ge_s) begin
      rem_o = diff_s;
      quo_o = {quo_i[62:0], 1'b1};
    end else begin
      rem_o = shifted_s[63:0];
      quo_o = {quo_i[62:0], 1'b0};
    end
  end

endmodule

// File: rtl/mdu_iter.sv
// mdu_iter: iterative RV64M multiply/divide unit in the execute stage.
// Raises e_wait towards the hazard unit while an operation runs and holds
// the result (done=1) until E advances (stall low). One op in flight.
//   clk, reset    - clock, asynchronous active-high reset
//   valid, op     - E-stage M-extension op request and its mdu_op_t code
//   a, b          - forwarded rs1 / rs2 operands
//   stall, flush  - stallE / flushE from the hazard unit
//   e_wait        - busy towards the hazard unit (combinational in IDLE)
//   done, result  - result valid for the instruction in E, rd value
module mdu_iter
  import pipes::*;
#(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            valid,
  input  mdu_op_t         op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            stall,
  input  logic            flush,
  output logic            e_wait,
  output logic            done,
  output logic [XLEN-1:0] result
);

  mdu_state_t   state_q, state_d, state_nx_s;
  mdu_op_t      op_q, op_d;
  logic [6:0]   cnt_q, cnt_d;
  logic         w_q, w_d, div_q, div_d, neg_q, neg_d;
  logic [127:0] p_q, p_d;          // {hi, lo}: product accumulator, or {rem, quo} for divide
  logic [63:0]  b_q, b_d;          // multiplicand / divisor magnitude
  logic [63:0]  res_q, res_d;
  logic         e_wait_s;

  logic         is_w_s, is_div_s, is_rem_s, sgn_a_s, sgn_b_s;
  logic [63:0]  a_ext_s, b_ext_s, a_mag_s, b_mag_s, dividend_s, spec_res_s;
  logic         a_neg_s, b_neg_s, div_zero_s, ovf_s, special_s;

  // Classify the incoming op: word size, divide/remainder, operand signedness.
  always_comb begin
    is_w_s   = 1'b0;
    is_div_s = 1'b0;
    is_rem_s = 1'b0;
    sgn_a_s  = 1'b0;
    sgn_b_s  = 1'b0;
    case (op)
      MULH:    begin sgn_a_s = 1'b1; sgn_b_s = 1'b1; end
      MULHSU:  sgn_a_s = 1'b1;
      DIV:     begin is_div_s = 1'b1; sgn_a_s = 1'b1; sgn_b_s = 1'b1; end
      DIVU:    is_div_s = 1'b1;
      REM:     begin is_div_s = 1'b1; is_rem_s = 1'b1; sgn_a_s = 1'b1; sgn_b_s = 1'b1; end
      REMU:    begin is_div_s = 1'b1; is_rem_s = 1'b1; end
      MULW:    is_w_s = 1'b1;
      DIVW:    begin is_w_s = 1'b1; is_div_s = 1'b1; sgn_a_s = 1'b1; sgn_b_s = 1'b1; end
      DIVUW:   begin is_w_s = 1'b1; is_div_s = 1'b1; end
      REMW:    begin is_w_s = 1'b1; is_div_s = 1'b1; is_rem_s = 1'b1; sgn_a_s = 1'b1; sgn_b_s = 1'b1; end
      REMUW:   begin is_w_s = 1'b1; is_div_s = 1'b1; is_rem_s = 1'b1; end
      default: ;  // MUL, MULHU: unsigned 64-bit
    endcase
  end

  // Word ops use the low 32 bits. MULW is zero-extended: its low 32-bit
  // product does not depend on operand extension.
  always_comb begin
    if (is_w_s) begin
      a_ext_s = sgn_a_s ? sext32(a[31:0]) : {32'd0, a[31:0]};
      b_ext_s = sgn_b_s ? sext32(b[31:0]) : {32'd0, b[31:0]};
    end else begin
      a_ext_s = a;
      b_ext_s = b;
    end
  end

  assign a_neg_s = sgn_a_s & a_ext_s[63];
  assign b_neg_s = sgn_b_s & b_ext_s[63];
  assign a_mag_s = neg_if(a_ext_s, a_neg_s);
  assign b_mag_s = neg_if(b_ext_s, b_neg_s);

  // Divide special cases finish without iterating, at the op's own width.
  assign dividend_s = is_w_s ? sext32(a[31:0]) : a;
  assign div_zero_s = is_div_s & (is_w_s ? (b[31:0] == 32'd0) : (b == 64'd0));
  assign ovf_s      = is_div_s & sgn_a_s &
                      (is_w_s ? ((a[31:0] == 32'h8000_0000) && (b[31:0] == 32'hFFFF_FFFF))
                              : ((a == 64'h8000_0000_0000_0000) && (b == 64'hFFFF_FFFF_FFFF_FFFF)));
  assign special_s  = div_zero_s | ovf_s;

  // Special-case result: quotient all ones / dividend, remainder dividend / zero.
  always_comb begin
    if (is_rem_s) begin
      spec_res_s = div_zero_s ? dividend_s : 64'd0;
    end else begin
      spec_res_s = div_zero_s ? 64'hFFFF_FFFF_FFFF_FFFF : dividend_s;
    end
  end

  // Datapath steps on the working registers.
  logic [64:0]  msum_s;
  logic [127:0] mp_s;
  logic [63:0]  mhi_s, drem_s, dquo_s, dq_s, dr_s, fin_s;
  logic [6:0]   last_s;

  assign msum_s = {1'b0, p_q[127:64]} + (p_q[0] ? {1'b0, b_q} : 65'd0);
  assign mp_s   = {msum_s, p_q[63:1]};
  // High half of the negated 128-bit product: borrow into hi only when lo is zero.
  assign mhi_s  = neg_q ? (~mp_s[127:64] + {63'd0, (mp_s[63:0] == 64'd0)}) : mp_s[127:64];

  mdu_div_step u_div_step (
    .rem_i     (p_q[127:64]),
    .quo_i     (p_q[63:0]),
    .divisor_i (b_q),
    .rem_o     (drem_s),
    .quo_o     (dquo_s)
  );

  assign dq_s   = neg_if(dquo_s, neg_q);
  assign dr_s   = neg_if(drem_s, neg_q);
  assign last_s = w_q ? 7'd31 : 7'd63;

  // Sign-corrected result of the final step, selected by the captured op.
  // After 32 multiply steps the word product sits in mp_s[95:32].
  always_comb begin
    case (op_q)
      MUL:                 fin_s = mp_s[63:0];
      MULH, MULHSU, MULHU: fin_s = mhi_s;
      MULW:                fin_s = sext32(mp_s[63:32]);
      DIV, DIVU:           fin_s = dq_s;
      REM, REMU:           fin_s = dr_s;
      DIVW, DIVUW:         fin_s = sext32(dq_s[31:0]);
      REMW, REMUW:         fin_s = sext32(dr_s[31:0]);
      default:             fin_s = 64'd0;
    endcase
  end

  // Next-state and capture logic; flush overrides every state.
  always_comb begin
    state_nx_s = state_q;
    cnt_d      = cnt_q;
    op_d       = op_q;
    w_d        = w_q;
    div_d      = div_q;
    neg_d      = neg_q;
    p_d        = p_q;
    b_d        = b_q;
    res_d      = res_q;
    e_wait_s   = 1'b0;
    case (state_q)
      IDLE: begin
        if (valid && !flush) begin
          e_wait_s = 1'b1;
          op_d     = op;
          w_d      = is_w_s;
          div_d    = is_div_s;
          neg_d    = is_rem_s ? a_neg_s : (a_neg_s ^ b_neg_s);
          b_d      = b_mag_s;
          cnt_d    = 7'd0;
          // Word divides start with the dividend in the upper half of quo so
          // its MSB is consumed first.
          p_d      = (is_div_s && is_w_s) ? {64'd0, a_mag_s[31:0], 32'd0} : {64'd0, a_mag_s};
          if (special_s) begin
            state_nx_s = DONE;
            res_d      = spec_res_s;
          end else begin
            state_nx_s = BUSY;
          end
        end else begin
          state_nx_s = IDLE;
        end
      end
      BUSY: begin
        e_wait_s = 1'b1;
        p_d      = div_q ? {drem_s, dquo_s} : mp_s;
        if (cnt_q == last_s) begin
          state_nx_s = DONE;
          res_d      = fin_s;
        end else begin
          cnt_d = cnt_q + 7'd1;
        end
      end
      DONE:    state_nx_s = stall ? DONE : IDLE;
      default: state_nx_s = IDLE;
    endcase
    state_d = flush ? IDLE : state_nx_s;
  end

  // State and working registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 7'd0;
      op_q    <= MUL;
      w_q     <= 1'b0;
      div_q   <= 1'b0;
      neg_q   <= 1'b0;
      p_q     <= 128'd0;
      b_q     <= 64'd0;
      res_q   <= 64'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      w_q     <= w_d;
      div_q   <= div_d;
      neg_q   <= neg_d;
      p_q     <= p_d;
      b_q     <= b_d;
      res_q   <= res_d;
    end
  end

  assign e_wait = e_wait_s;
  assign done   = (state_q == DONE);
  assign result = res_q;

endmodule

// File: tb/tb_mdu_iter.sv
// tb_mdu_iter: self-checking bench for mdu_iter (directed table, hold/flush/
// reset sequences, random ops against an arithmetic reference model).
module tb_mdu_iter;
  import pipes::*;

  logic        clk = 1'b0;
  logic        reset, valid, stall, flush;
  mdu_op_t     op;
  logic [63:0] a, b;
  logic        e_wait, done;
  logic [63:0] result;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mdu_iter #(.XLEN(64)) dut (
    .clk(clk), .reset(reset), .valid(valid), .op(op), .a(a), .b(b),
    .stall(stall), .flush(flush), .e_wait(e_wait), .done(done), .result(result)
  );

  typedef struct {
    mdu_op_t     op;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] res;
    int          lat;
  } vec_t;

  vec_t vecs[15];

  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] IMIN = 64'h8000_0000_0000_0000;

  task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] sx(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

  // Reference result straight from the RV64M arithmetic definitions.
  function automatic logic [63:0] ref_result(input mdu_op_t o, input logic [63:0] x, input logic [63:0] y);
    logic [127:0]       p;
    logic signed [63:0] sx64, sy64;
    logic signed [31:0] sx32, sy32;
    logic [31:0]        ux, uy, w;
    sx64 = x; sy64 = y; sx32 = x[31:0]; sy32 = y[31:0]; ux = x[31:0]; uy = y[31:0];
    case (o)
      MUL:    return x * y;
      MULH:   begin p = {{64{x[63]}}, x} * {{64{y[63]}}, y}; return p[127:64]; end
      MULHSU: begin p = {{64{x[63]}}, x} * {64'd0, y}; return p[127:64]; end
      MULHU:  begin p = {64'd0, x} * {64'd0, y}; return p[127:64]; end
      DIV:    if (y == 64'd0) return ONES; else if (x == IMIN && y == ONES) return x; else return sx64 / sy64;
      DIVU:   if (y == 64'd0) return ONES; else return x / y;
      REM:    if (y == 64'd0) return x; else if (x == IMIN && y == ONES) return 64'd0; else return sx64 % sy64;
      REMU:   if (y == 64'd0) return x; else return x % y;
      MULW:   begin w = ux * uy; return sx(w); end
      DIVW:   if (uy == 32'd0) return ONES;
              else if (ux == 32'h8000_0000 && uy == 32'hFFFF_FFFF) return sx(ux);
              else begin w = sx32 / sy32; return sx(w); end
      DIVUW:  if (uy == 32'd0) return ONES; else begin w = ux / uy; return sx(w); end
      REMW:   if (uy == 32'd0) return sx(ux);
              else if (ux == 32'h8000_0000 && uy == 32'hFFFF_FFFF) return 64'd0;
              else begin w = sx32 % sy32; return sx(w); end
      REMUW:  if (uy == 32'd0) return sx(ux); else begin w = ux % uy; return sx(w); end
      default: return 64'd0;
    endcase
  endfunction

  // Reference latency: specials 1 cycle, word ops 33, others 65.
  function automatic int ref_lat(input mdu_op_t o, input logic [63:0] x, input logic [63:0] y);
    logic w, dv, sg;
    w  = (o == MULW) || (o == DIVW) || (o == DIVUW) || (o == REMW) || (o == REMUW);
    dv = (o == DIV) || (o == DIVU) || (o == REM) || (o == REMU) ||
         (o == DIVW) || (o == DIVUW) || (o == REMW) || (o == REMUW);
    sg = (o == DIV) || (o == REM) || (o == DIVW) || (o == REMW);
    if (dv && w && (y[31:0] == 32'd0)) return 1;
    if (dv && !w && (y == 64'd0)) return 1;
    if (sg && w && x[31:0] == 32'h8000_0000 && y[31:0] == 32'hFFFF_FFFF) return 1;
    if (sg && !w && x == IMIN && y == ONES) return 1;
    return w ? 33 : 65;
  endfunction

  function automatic logic [63:0] pick_operand();
    case ($urandom_range(0, 6))
      0:       return 64'd0;
      1:       return ONES;
      2:       return IMIN;
      3:       return 64'(unsigned'($urandom_range(0, 20)));
      4:       return 64'h0000_0000_8000_0000;
      5:       return sx($urandom());
      default: return {$urandom(), $urandom()};
    endcase
  endfunction

  // Issue one op, measure latency, check e_wait profile, result, return to IDLE.
  task automatic run_op(input string name, input mdu_op_t o, input logic [63:0] x,
                        input logic [63:0] y, input logic [63:0] exp_res, input int exp_lat,
                        input logic hold);
    int   cyc;
    logic got, ew_ok;
    @(negedge clk);
    op = o; a = x; b = y; valid = 1'b1; stall = hold;
    #1;
    ew_ok = (e_wait === 1'b1) && (done === 1'b0);
    cyc = 0; got = 1'b0;
    while (!got && cyc < 100) begin
      @(posedge clk); #1; cyc++;
      if (done === 1'b1) got = 1'b1;
      else if (e_wait !== 1'b1) ew_ok = 1'b0;
    end
    if (!got) begin
      n_tests++; n_fail++;
      $display("FAIL %s timeout: done not seen within %0d cycles", name, cyc);
    end
    check64({name, " result"}, result, exp_res);
    check64({name, " latency"}, 64'(cyc), 64'(exp_lat));
    check64({name, " ewait_busy"}, {63'd0, ew_ok}, 64'd1);
    check64({name, " ewait_done"}, {63'd0, e_wait}, 64'd0);
    if (hold) begin
      for (int k = 0; k < 5; k++) begin
        @(posedge clk); #1;
        check64($sformatf("%s hold%0d done", name, k), {63'd0, done}, 64'd1);
        check64($sformatf("%s hold%0d result", name, k), result, exp_res);
        check64($sformatf("%s hold%0d ewait", name, k), {63'd0, e_wait}, 64'd0);
      end
      stall = 1'b0;
    end
    valid = 1'b0;
    @(posedge clk); #1;
    check64({name, " idle_done"}, {62'd0, done, e_wait}, 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic saw_done;
    mdu_op_t ro;
    logic [63:0] rx, ry;

    vecs[0]  = '{DIV,    64'd100,               64'd7,                  64'd14,                 65};
    vecs[1]  = '{REM,    64'd100,               64'd7,                  64'd2,                  65};
    vecs[2]  = '{MULH,   IMIN,                  ONES,                   64'd0,                  65};
    vecs[3]  = '{MUL,    IMIN,                  ONES,                   IMIN,                   65};
    vecs[4]  = '{MULHU,  ONES,                  ONES,                   64'hFFFF_FFFF_FFFF_FFFE, 65};
    vecs[5]  = '{DIV,    64'd5,                 64'd0,                  ONES,                   1};
    vecs[6]  = '{DIV,    IMIN,                  ONES,                   IMIN,                   1};
    vecs[7]  = '{REM,    IMIN,                  ONES,                   64'd0,                  1};
    vecs[8]  = '{DIVW,   64'h0000_0000_8000_0000, ONES,                 64'hFFFF_FFFF_8000_0000, 1};
    vecs[9]  = '{MULW,   64'h0000_0000_7FFF_FFFF, 64'd2,                64'hFFFF_FFFF_FFFF_FFFE, 33};
    vecs[10] = '{DIVU,   64'd9,                 64'd2,                  64'd4,                  65};
    vecs[11] = '{REMUW,  64'h0000_0000_FFFF_FFFF, 64'h0000_0001_0000_0000, ONES,                1};
    vecs[12] = '{MULHSU, ONES,                  64'd2,                  ONES,                   65};
    vecs[13] = '{REMW,   64'hFFFF_FFFF_FFFF_FFF9, 64'd2,                ONES,                   33};
    vecs[14] = '{DIVUW,  64'h0000_0000_FFFF_FFFE, 64'd1,                64'hFFFF_FFFF_FFFF_FFFE, 33};

    reset = 1'b1; valid = 1'b0; stall = 1'b0; flush = 1'b0; op = MUL; a = 64'd0; b = 64'd0;
    repeat (2) @(posedge clk);
    #1;
    check64("reset outputs", {done, e_wait, result}, 66'd0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 15; i++)
      run_op($sformatf("vec%0d_%s", i, vecs[i].op.name()), vecs[i].op, vecs[i].a, vecs[i].b,
             vecs[i].res, vecs[i].lat, 1'b0);

    // Hold in DONE with stall high and valid still asserted.
    run_op("hold_div", DIV, 64'd100, 64'd7, 64'd14, 65, 1'b1);

    // Flush in BUSY cycle 10: e_wait stays up that cycle, then IDLE, never done.
    @(negedge clk);
    op = DIVU; a = 64'd100; b = 64'd7; valid = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    flush = 1'b1; valid = 1'b0;
    #1;
    check64("flush ewait_busy", {63'd0, e_wait}, 64'd1);
    @(posedge clk); #1;
    check64("flush idle", {62'd0, done, e_wait}, 64'd0);
    flush = 1'b0;
    saw_done = 1'b0;
    for (int k = 0; k < 70; k++) begin
      @(posedge clk); #1;
      if (done === 1'b1) saw_done = 1'b1;
    end
    check64("flush no_done", {63'd0, saw_done}, 64'd0);

    // Reset in BUSY cycle 20 clears everything; a fresh op then works.
    @(negedge clk);
    op = DIV; a = 64'hFFFF_FFFF_FFFF_FF9C; b = 64'd7; valid = 1'b1;
    repeat (20) @(posedge clk);
    @(negedge clk);
    reset = 1'b1; valid = 1'b0;
    #1;
    check64("midreset outputs", {done, e_wait, result}, 66'd0);
    @(negedge clk);
    reset = 1'b0;
    run_op("divu_after_reset", DIVU, 64'd9, 64'd2, 64'd4, 65, 1'b0);

    // Random ops against the reference model.
    for (int i = 0; i < 50; i++) begin
      ro = mdu_op_t'($urandom_range(0, 12));
      rx = pick_operand();
      ry = pick_operand();
      run_op($sformatf("rnd%0d_%s_%h_%h", i, ro.name(), rx, ry), ro, rx, ry,
             ref_result(ro, rx, ry), ref_lat(ro, rx, ry), 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
